// File: rtl/mac_fifo_seq_if.sv
// mac_fifo_seq_if
//   Handshake/control bundle between the MAC/FIFO sequencer and its datapath.
//   master : the sequencer (drives FIFO wr/rd requests and MAC controls)
//   slave  : the datapath / stream source side
//   Signals:
//     start, in_valid, in_ready      job start and shared input-stream handshake
//     fullA, emptyA, fullB, emptyB   FIFO status flags
//     wrenA, wrenB, rdenA, rdenB     FIFO write/read requests
//     mac_en, mac_clr                MAC row enables and common clear
//     busy, done, err                job status
interface mac_fifo_seq_if #(parameter int N = 8);
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] fullA;
    logic [N-1:0] emptyA;
    logic         fullB;
    logic         emptyB;
    logic [N-1:0] wrenA;
    logic         wrenB;
    logic [N-1:0] rdenA;
    logic         rdenB;
    logic [N-1:0] mac_en;
    logic         mac_clr;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        input  start, in_valid, fullA, emptyA, fullB, emptyB,
        output in_ready, wrenA, wrenB, rdenA, rdenB, mac_en, mac_clr, busy, done, err
    );

    modport slave (
        output start, in_valid, fullA, emptyA, fullB, emptyB,
        input  in_ready, wrenA, wrenB, rdenA, rdenB, mac_en, mac_clr, busy, done, err
    );
endinterface

// File: rtl/mac_fifo_seq.sv
// mac_fifo_seq
//   Control-only sequencer for the vectored MAC/FIFO datapath. Steers one
//   shared input stream into N A-row FIFOs (row-major) and then the B FIFO,
//   then drains all FIFOs in lockstep for N cycles while issuing MAC enables
//   delayed by the FIFO read latency. Pulses done at the end of the job.
//   Parameters: N (matrix dimension), RD_LAT (FIFO rdreq->q latency, 1..3).
//   Ports: clk, rst_n (synchronous, active low), bus (mac_fifo_seq_if.master).
//   Optional build macro MAC_FIFO_SEQ_ERR_CHECK_EN: enables the sticky err
//   flag (read from an empty FIFO during COMPUTE, or start while busy).
//   Without it err is tied low.
module mac_fifo_seq #(
    parameter int N      = 8,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mac_fifo_seq_if.master       bus
);
    localparam int            CW   = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, FLUSH} stateT;

    stateT         state, stateNext;
    logic [CW-1:0] row, rowNext;
    logic [CW-1:0] col, colNext;
    logic [CW-1:0] k, kNext;
    logic [1:0]    flushCnt, flushCntNext;
    logic          macClr, clrNext;
    logic          rowFull, accept, inReady;
    logic [N-1:0]  wrenA, rdenA;
    logic          wrenB, rdenB, done;
    // Stage s holds rdenA delayed by s+1 cycles.
    logic [RD_LAT-1:0][N-1:0] enPipe;

    // Full flag of the A FIFO currently being loaded.
    always_comb begin
        rowFull = 1'b0;
        for (int i = 0; i < N; i++)
            if (row == CW'(i)) rowFull = bus.fullA[i];
    end

    always_comb begin
        stateNext    = state;
        rowNext      = row;
        colNext      = col;
        kNext        = k;
        flushCntNext = flushCnt;
        clrNext      = 1'b0;
        inReady      = 1'b0;
        accept       = 1'b0;
        wrenA        = '0;
        wrenB        = 1'b0;
        rdenA        = '0;
        rdenB        = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    stateNext = LOAD_A;
                    rowNext   = '0;
                    colNext   = '0;
                    clrNext   = 1'b1;
                end
            end
            LOAD_A: begin
                inReady = ~rowFull;
                accept  = bus.in_valid & inReady;
                for (int i = 0; i < N; i++)
                    wrenA[i] = accept && (row == CW'(i));
                if (accept) begin
                    if (col == LAST) begin
                        colNext = '0;
                        if (row == LAST) begin
                            rowNext   = '0;
                            stateNext = LOAD_B;
                        end else begin
                            rowNext = row + 1'b1;
                        end
                    end else begin
                        colNext = col + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                inReady = ~bus.fullB;
                accept  = bus.in_valid & inReady;
                wrenB   = accept;
                if (accept) begin
                    if (col == LAST) begin
                        colNext   = '0;
                        kNext     = '0;
                        stateNext = COMPUTE;
                    end else begin
                        colNext = col + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                rdenA = '1;
                rdenB = 1'b1;
                if (k == LAST) begin
                    kNext        = '0;
                    flushCntNext = '0;
                    stateNext    = FLUSH;
                end else begin
                    kNext = k + 1'b1;
                end
            end
            FLUSH: begin
                // Wait out the read latency so the last En reaches the MACs.
                if (flushCnt == 2'(RD_LAT - 1)) begin
                    done         = 1'b1;
                    flushCntNext = '0;
                    stateNext    = IDLE;
                end else begin
                    flushCntNext = flushCnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            k        <= '0;
            flushCnt <= '0;
            macClr   <= 1'b0;
            enPipe   <= '0;
        end else begin
            state     <= stateNext;
            row       <= rowNext;
            col       <= colNext;
            k         <= kNext;
            flushCnt  <= flushCntNext;
            macClr    <= clrNext;
            enPipe[0] <= rdenA;
            for (int s = 1; s < RD_LAT; s++)
                enPipe[s] <= enPipe[s-1];
        end
    end

    assign bus.in_ready = inReady;
    assign bus.wrenA    = wrenA;
    assign bus.wrenB    = wrenB;
    assign bus.rdenA    = rdenA;
    assign bus.rdenB    = rdenB;
    assign bus.mac_en   = enPipe[RD_LAT-1];
    assign bus.mac_clr  = macClr;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done;

`ifdef MAC_FIFO_SEQ_ERR_CHECK_EN
    logic errQ;
    always_ff @(posedge clk) begin
        if (!rst_n)
            errQ <= 1'b0;
        else if ((state == COMPUTE && ((|bus.emptyA) || bus.emptyB)) ||
                 (bus.start && state != IDLE))
            errQ <= 1'b1;
    end
    assign bus.err = errQ;
`else
    logic unusedEmpty;
    assign unusedEmpty = ^{bus.emptyA, bus.emptyB};
    assign bus.err     = 1'b0;
`endif
endmodule

// File: tb/tb_mac_fifo_seq.sv
module tb_mac_fifo_seq;
    localparam int N  = 8;
    localparam int OW = 3 * N + 7;
    localparam int NW = N * N + N;
`ifdef MAC_FIFO_SEQ_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic errState = 1'b0;

    always #5 clk = ~clk;

    mac_fifo_seq_if #(.N(N)) b1 ();
    mac_fifo_seq_if #(.N(N)) b3 ();

    // Second instance with RD_LAT=3 sees exactly the same inputs.
    assign b3.start    = b1.start;
    assign b3.in_valid = b1.in_valid;
    assign b3.fullA    = b1.fullA;
    assign b3.emptyA   = b1.emptyA;
    assign b3.fullB    = b1.fullB;
    assign b3.emptyB   = b1.emptyB;

    mac_fifo_seq #(.N(N), .RD_LAT(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(b1));
    mac_fifo_seq #(.N(N), .RD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    // Reference model: the job is a stream of NW accepted words (word w goes to
    // A row w/N, or to B once w >= N*N); after the last word, cc counts cycles:
    // reads for cc < N, En for L <= cc < N+L, done at cc == N+L-1.
    task automatic run_job(input int validPct, input int fullPct,
                           input int stallCyc, input int stallLen,
                           input int startCc, input int emptyCc,
                           output int done1, output int done3, output int nDone1);
        int w, cc, cyc;
        logic loading, acc, tgtFull, eRdy, eRd, eWrB;
        logic [N-1:0] eWrA, eEn1, eEn3;
        logic eBusy1, eBusy3, eDone1, eDone3;
        logic [OW-1:0] e1, e3, g1, g3;
        w = 0; cc = -1; done1 = -1; done3 = -1; nDone1 = 0;
        b1.start = 1'b1;
        b1.in_valid = ($urandom_range(99) < validPct);
        b1.fullA = '0; b1.fullB = 1'b0; b1.emptyA = '0; b1.emptyB = 1'b0;
        @(negedge clk);
        e1 = '0; e1[0] = errState;
        g1 = {b1.in_ready, b1.wrenA, b1.wrenB, b1.rdenA, b1.rdenB, b1.mac_en, b1.mac_clr, b1.busy, b1.done, b1.err};
        checks++;
        if (g1 !== e1) begin
            errors++;
            $display("FAIL idle_before_start got %h exp %h", g1, e1);
        end
        @(posedge clk); #1;
        cyc = 1;
        while (cyc < 3000 && cc <= N + 3) begin
            loading = (w < NW);
            b1.start = (!loading && cc == startCc);
            b1.in_valid = ($urandom_range(99) < validPct);
            for (int i = 0; i < N; i++) b1.fullA[i] = ($urandom_range(99) < fullPct);
            if (cyc >= stallCyc && cyc < stallCyc + stallLen) b1.fullA[3] = 1'b1;
            b1.fullB = ($urandom_range(99) < fullPct);
            b1.emptyA = (!loading && cc == emptyCc) ? 8'h20 : 8'h00;
            b1.emptyB = 1'b0;
            @(negedge clk);
            tgtFull = (w < N * N) ? b1.fullA[w / N] : b1.fullB;
            eRdy = loading && !tgtFull;
            acc  = eRdy && b1.in_valid;
            eWrA = '0;
            if (acc && w < N * N) eWrA[w / N] = 1'b1;
            eWrB = acc && (w >= N * N);
            eRd  = !loading && cc < N;
            eEn1 = (!loading && cc >= 1 && cc < N + 1) ? '1 : '0;
            eEn3 = (!loading && cc >= 3 && cc < N + 3) ? '1 : '0;
            eBusy1 = loading || cc <= N;
            eBusy3 = loading || cc <= N + 2;
            eDone1 = !loading && cc == N;
            eDone3 = !loading && cc == N + 2;
            e1 = {eRdy, eWrA, eWrB, {N{eRd}}, eRd, eEn1, (cyc == 1), eBusy1, eDone1, errState};
            e3 = {eRdy, eWrA, eWrB, {N{eRd}}, eRd, eEn3, (cyc == 1), eBusy3, eDone3, errState};
            g1 = {b1.in_ready, b1.wrenA, b1.wrenB, b1.rdenA, b1.rdenB, b1.mac_en, b1.mac_clr, b1.busy, b1.done, b1.err};
            g3 = {b3.in_ready, b3.wrenA, b3.wrenB, b3.rdenA, b3.rdenB, b3.mac_en, b3.mac_clr, b3.busy, b3.done, b3.err};
            checks++;
            if (g1 !== e1) begin
                errors++;
                $display("FAIL outputs_lat1 cyc %0d got %h exp %h", cyc, g1, e1);
            end
            checks++;
            if (g3 !== e3) begin
                errors++;
                $display("FAIL outputs_lat3 cyc %0d got %h exp %h", cyc, g3, e3);
            end
            if (b1.done === 1'b1) begin
                nDone1++;
                if (done1 < 0) done1 = cyc;
            end
            if (b3.done === 1'b1 && done3 < 0) done3 = cyc;
            if (ERR_EN && (b1.start || (eRd && (b1.emptyA != 0 || b1.emptyB)))) errState = 1'b1;
            if (loading) begin
                if (acc) begin
                    w++;
                    if (w == NW) cc = 0;
                end
            end else begin
                cc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        b1.start = 1'b0; b1.in_valid = 1'b0; b1.fullA = '0; b1.fullB = 1'b0; b1.emptyA = '0;
        checks++;
        if (cc <= N + 3) begin
            errors++;
            $display("FAIL job_timeout words %0d cc %0d exp job end", w, cc);
        end
    endtask

    task automatic test_reset();
        logic [OW-1:0] g1, g3;
        b1.start = 1'b1; b1.in_valid = 1'b1; b1.fullA = '0; b1.fullB = 1'b0;
        b1.emptyA = '0; b1.emptyB = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        g1 = {b1.in_ready, b1.wrenA, b1.wrenB, b1.rdenA, b1.rdenB, b1.mac_en, b1.mac_clr, b1.busy, b1.done, b1.err};
        g3 = {b3.in_ready, b3.wrenA, b3.wrenB, b3.rdenA, b3.rdenB, b3.mac_en, b3.mac_clr, b3.busy, b3.done, b3.err};
        checks++;
        if (g1 !== '0 || g3 !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h/%h exp 0", g1, g3);
        end
        b1.start = 1'b0; b1.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        errState = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int d1, d3, n1;
        run_job(100, 0, -1, 0, -1, -1, d1, d3, n1);
        checks++;
        if (d1 !== 81 || d3 !== 83 || n1 !== 1) begin
            errors++;
            $display("FAIL basic_done got %0d/%0d n%0d exp 81/83 n1", d1, d3, n1);
        end
    endtask

    task automatic test_backpressure();
        int d1, d3, n1;
        run_job(100, 0, 29, 5, -1, -1, d1, d3, n1);
        checks++;
        if (d1 !== 86 || d3 !== 88) begin
            errors++;
            $display("FAIL backpressure_done got %0d/%0d exp 86/88", d1, d3);
        end
    endtask

    task automatic test_start_during_compute();
        int d1, d3, n1;
        run_job(100, 0, -1, 0, 3, -1, d1, d3, n1);
        checks++;
        if (n1 !== 1 || d1 !== 81) begin
            errors++;
            $display("FAIL start_in_compute done count %0d at %0d exp 1 at 81", n1, d1);
        end
        checks++;
        if (b1.err !== ERR_EN || b3.err !== ERR_EN) begin
            errors++;
            $display("FAIL start_in_compute_err got %b/%b exp %b", b1.err, b3.err, ERR_EN);
        end
    endtask

    task automatic test_reset_mid_job();
        logic [OW-1:0] g1, g3;
        int d1, d3, n1;
        b1.start = 1'b1; b1.in_valid = 1'b1; b1.fullA = '0; b1.fullB = 1'b0;
        @(posedge clk); #1;
        b1.start = 1'b0;
        repeat (N * N + 2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (b1.busy !== 1'b1 || b1.wrenB !== 1'b1 || b1.wrenA !== '0) begin
            errors++;
            $display("FAIL mid_job_in_load_b busy %b wrenB %b wrenA %h exp 1 1 00", b1.busy, b1.wrenB, b1.wrenA);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        errState = 1'b0;
        @(negedge clk);
        g1 = {b1.in_ready, b1.wrenA, b1.wrenB, b1.rdenA, b1.rdenB, b1.mac_en, b1.mac_clr, b1.busy, b1.done, b1.err};
        g3 = {b3.in_ready, b3.wrenA, b3.wrenB, b3.rdenA, b3.rdenB, b3.mac_en, b3.mac_clr, b3.busy, b3.done, b3.err};
        checks++;
        if (g1 !== '0 || g3 !== '0) begin
            errors++;
            $display("FAIL reset_mid_job got %h/%h exp 0", g1, g3);
        end
        b1.in_valid = 1'b0;
        @(posedge clk); #1;
        run_job(100, 0, -1, 0, -1, -1, d1, d3, n1);
        checks++;
        if (d1 !== 81 || n1 !== 1) begin
            errors++;
            $display("FAIL after_reset_job done %0d n%0d exp 81 n1", d1, n1);
        end
    endtask

    task automatic test_empty_err();
        int d1, d3, n1;
        test_reset();
        run_job(100, 0, -1, 0, -1, 5, d1, d3, n1);
        checks++;
        if (d1 !== 81 || d3 !== 83) begin
            errors++;
            $display("FAIL empty_seq_done got %0d/%0d exp 81/83", d1, d3);
        end
        checks++;
        if (b1.err !== ERR_EN) begin
            errors++;
            $display("FAIL empty_err got %b exp %b", b1.err, ERR_EN);
        end
    endtask

    task automatic test_random();
        int d1, d3, n1;
        for (int j = 0; j < 4; j++) begin
            run_job(60 + 10 * j, 10 + 5 * j, -1, 0, -1, -1, d1, d3, n1);
            checks++;
            if (n1 !== 1 || d1 < 81 || d3 !== d1 + 2) begin
                errors++;
                $display("FAIL random_job%0d done %0d/%0d n%0d exp one done >=81, lat3 +2", j, d1, d3, n1);
            end
        end
    endtask

    initial begin
        b1.start = 1'b0; b1.in_valid = 1'b0; b1.fullA = '0; b1.fullB = 1'b0;
        b1.emptyA = '0; b1.emptyB = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_start_during_compute();
        test_reset_mid_job();
        test_empty_err();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mac_fifo_seq.md
Name: mac_fifo_seq

Overview:
- Sequencer for the vectored MAC/FIFO datapath: N row FIFOs for the A matrix, one B FIFO, and an N-row MAC array.
- Steers a single shared input stream into the A row FIFOs and then the B FIFO.
- Drains all FIFOs in lockstep into the MACs, issuing MAC clear/enable aligned to FIFO read latency.
- Signals completion. Purely control: data buses bypass this block.

Parameters:
- N, 8, matrix dimension: number of A FIFOs, MAC rows, and elements per row and of B.
- RD_LAT, 1, cycles from FIFO rdreq to valid q; legal values 1..3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a load+compute job; sampled only in IDLE
- in_valid  in  1  shared datain word valid
- in_ready  out  1  shared datain word accepted this cycle when in_valid&in_ready
- fullA  in  N  per-row A FIFO wrfull
- emptyA  in  N  per-row A FIFO rdempty
- fullB  in  1  B FIFO wrfull
- emptyB  in  1  B FIFO rdempty
- wrenA  out  N  A FIFO wrreq, at most one bit high
- wrenB  out  1  B FIFO wrreq
- rdenA  out  N  A FIFO rdreq, all bits equal
- rdenB  out  1  B FIFO rdreq
- mac_en  out  N  MAC En per row
- mac_clr  out  1  MAC Clr
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, all counters 0, every output 0 (in_ready, wrenA, wrenB, rdenA, rdenB, mac_en, mac_clr, busy, done, err).
- Reset mid-job aborts immediately with the same values. FIFO contents are not flushed; the integrator must reset the FIFOs alongside.
- States: IDLE -> LOAD_A -> LOAD_B -> COMPUTE -> FLUSH -> IDLE.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD_A with row=0, col=0, and mac_clr=1 for exactly that transition cycle (registered, high during the first LOAD_A cycle).
- LOAD_A:
  - in_ready = ~fullA[row]; wrenA[row] = in_valid & in_ready.
  - Each accepted word increments col. At col=N-1 accepted, col wraps to 0 and row increments.
  - Acceptance of word (row=N-1, col=N-1) -> LOAD_B. Row-major order.
- LOAD_B:
  - in_ready = ~fullB; wrenB = in_valid & in_ready.
  - N accepted words -> COMPUTE with k=0.
- COMPUTE:
  - rdenA = all ones and rdenB=1 for exactly N consecutive cycles; k counts 0..N-1.
  - No stall. After N cycles -> FLUSH.
- mac_en[i] is rdenA[i] delayed by RD_LAT cycles through a shift register. It runs through COMPUTE and FLUSH, giving N En cycles per row.
- FLUSH:
  - Lasts RD_LAT cycles until the mac_en pipe is empty.
  - Its last cycle asserts done=1 for one cycle -> IDLE.
- busy is registered high from the first LOAD_A cycle through the done cycle inclusive.
- start while busy is ignored. in_valid outside LOAD_A/LOAD_B is ignored: in_ready=0, no wren.
- Simultaneous in_valid and full: no write, counters hold, word stays pending.
- Total latency from start to done: 1 + (N*N + N accepted words, with stalls) + N + RD_LAT cycles.
- Counter widths are $clog2(N)+1; no wrap-around beyond the stated limits.

Optional Feature:
- Macro MAC_FIFO_SEQ_ERR_CHECK_EN.
- Defined: err sets sticky (cleared only by reset) when:
  - any emptyA bit or emptyB is high in a COMPUTE cycle (read from an empty FIFO), or
  - start arrives while busy.
  - err rises the cycle after the offending condition.
- Undefined: err tied 0 and the checking logic is absent. All other behaviour is identical.

Test Plan:
- N=8, RD_LAT=1: start, stream 72 words with in_valid=1 and no full -> wrenA[0] high cycles 1-8, wrenA[7] cycles 57-64, wrenB cycles 65-72; rdenA=0xFF cycles 73-80; mac_en=0xFF cycles 74-81; done pulse cycle 81; mac_clr only at cycle 1.
- Backpressure: fullA[3]=1 for 5 cycles mid-row 3 -> in_ready=0, no wren, col holds; resumes with the same word; done delayed by exactly 5 cycles.
- start pulsed during COMPUTE -> ignored, one done only; with MAC_FIFO_SEQ_ERR_CHECK_EN err=1 thereafter, without it err=0.
- rst_n=0 during LOAD_B -> next cycle all outputs 0 and state IDLE; a new start runs a full job correctly.
- RD_LAT=3 -> mac_en trails rdenA by 3 cycles; FLUSH lasts 3 cycles; done arrives 3 cycles after the last rdenA.
- With ERR_CHECK_EN, emptyA[5]=1 in a COMPUTE cycle -> err=1 the following cycle and stays 1 until reset; sequencing is otherwise unchanged.
